synth_voice_allocator: RTL and testbench
========================================

Name: synth_voice_allocator

Overview:
- Sits between the MMIO/UART command decoder and the synth datapath.
- Accepts one opcode+data command at a time and owns all synth configuration registers: modulator FCW, modulator shift, synth shift, per-voice carrier FCWs and note enables.
- Allocates NOTE_START commands to free voices, steals the least-recently-started voice when all voices are busy, and releases voices on NOTE_STOP.

Parameters:
N_VOICES, 4, number of carrier voices.
FCW_WIDTH, 24, width of every frequency control word.
SHIFT_WIDTH, 5, width of the mod/synth shift fields.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  allocator can accept a command
cmd_op  in  3  opcode
cmd_data  in  FCW_WIDTH  operand (FCW, or shift in low SHIFT_WIDTH bits)
carrier_fcws  out  N_VOICES*FCW_WIDTH  voice i FCW at [FCW_WIDTH*(i+1)-1 : FCW_WIDTH*i]
note_en  out  N_VOICES  voice i enabled
mod_fcw  out  FCW_WIDTH  modulator FCW
mod_shift  out  SHIFT_WIDTH  modulator shift
synth_shift  out  SHIFT_WIDTH  synth output shift
steal_pulse  out  1  one-cycle pulse when an active voice was overwritten
err_pulse  out  1  one-cycle pulse on illegal opcode or NOTE_START with FCW 0
active_count  out  clog2(N_VOICES+1)  popcount of note_en, registered

Clock and reset: clk is the single clock; rst_n is asynchronous, active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs and registers go to 0, except cmd_ready = 1.
  - The FSM goes to IDLE.
  - Age ranks are initialised to rank[i] = i.
- Opcodes:
  - 1 SET_MOD_FCW
  - 2 SET_MOD_SHIFT
  - 3 NOTE_START
  - 4 NOTE_STOP
  - 5 SET_SYNTH_SHIFT
  - 6 ALL_OFF
  - 0 and 7 are illegal.
- FSM has two states, IDLE and EXEC:
  - IDLE: cmd_ready = 1. A handshake is cmd_valid && cmd_ready at a rising edge; op and data are captured and the FSM moves to EXEC.
  - EXEC: cmd_ready = 0. The command is executed and all output registers update at the next edge. The FSM then returns to IDLE.
- Timing:
  - Latency from the handshake edge to visible outputs is 1 cycle.
  - Maximum throughput is 1 command per 2 cycles.
- Register commands:
  - SET_MOD_FCW: mod_fcw <= data.
  - SET_*_SHIFT: the target shift <= data[SHIFT_WIDTH-1:0]; upper bits are ignored.
- NOTE_START with FCW f, resolved in priority order:
  - f == 0: no state change; err_pulse.
  - Some active voice already holds f: retrigger. No FCW or enable change; that voice's rank becomes 0.
  - Otherwise, if a free voice exists: choose the lowest-index voice with note_en = 0, load f, set its enable, set its rank to 0.
  - Otherwise, all voices are active: steal the voice with rank N_VOICES-1, load f, keep its enable set, set its rank to 0, and pulse steal_pulse.
- Rank update on any allocation or retrigger of voice v: every voice with rank < old rank[v] increments its rank; rank[v] <= 0. The ranks always remain a permutation of 0..N_VOICES-1.
- NOTE_STOP with FCW f:
  - Clear note_en of the active voice holding f. Its FCW is retained; ranks are unchanged.
  - If no active voice holds f: no change and no pulse.
- ALL_OFF: note_en <= 0; FCWs and ranks are retained.
- Illegal opcode: no state change; err_pulse.
- active_count is updated in the same edge as note_en.
- cmd_valid without a handshake has no effect. cmd_op and cmd_data are sampled only at the handshake edge.
- Reset in EXEC: the pending command is discarded and all state resets.

Decomposition:
- Shared package synth_pkg holds:
  - the opcode localparams (OP_SET_MOD_FCW = 3'd1 … OP_ALL_OFF = 3'd6);
  - the FCW_WIDTH and SHIFT_WIDTH defaults;
  - the state encoding.
- One sub-module, voice_lru_rank: holds the rank registers, accepts touch/voice_idx, and outputs oldest_idx.
- Matching, free-slot priority encoding and the FSM stay in synth_voice_allocator.

Test Plan:
- Reset then op2 data 8, op5 data 2, op1 data 1118481 → mod_shift = 8, synth_shift = 2, mod_fcw = 1118481, each visible 1 cycle after its handshake; cmd_ready low for exactly 1 cycle per command.
- op3 2796202, then op3 1006202 → voice0 = 2796202, voice1 = 1006202, note_en = 4'b0011, active_count = 2.
- op3 2796202 again → retrigger: note_en stays 4'b0011, no steal_pulse; op4 2796202 → note_en = 4'b0010, voice0 FCW still 2796202.
- Start FCWs 100, 200, 300, 400 from reset, then op3 500 → voice0 = 500, steal_pulse for one cycle, note_en = 4'b1111. Then op3 600 → voice1 = 600.
- op7, and op3 with data 0 → err_pulse each time, no register change; op4 of an unplayed FCW 999 → no change, no pulse.
- Hold cmd_valid high across back-to-back commands, then assert rst_n low during EXEC → command dropped, all outputs 0, cmd_ready = 1 after reset releases; op6 with 3 voices active → note_en = 0, active_count = 0.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: opcodes, default widths and FSM encoding
// shared by the synth voice allocator slice.
package synth_pkg;

  localparam int DEF_FCW_WIDTH   = 24;
  localparam int DEF_SHIFT_WIDTH = 5;

  localparam logic [2:0] OP_SET_MOD_FCW     = 3'd1;
  localparam logic [2:0] OP_SET_MOD_SHIFT   = 3'd2;
  localparam logic [2:0] OP_NOTE_START      = 3'd3;
  localparam logic [2:0] OP_NOTE_STOP       = 3'd4;
  localparam logic [2:0] OP_SET_SYNTH_SHIFT = 3'd5;
  localparam logic [2:0] OP_ALL_OFF         = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/voice_lru_rank.sv
// voice_lru_rank: age rank per voice (0 = newest).
// Ports: clk, rst_n, touch/voice_idx in, oldest_idx out.
module voice_lru_rank #(
  parameter int N_VOICES = 4,
  parameter int IDX_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch,
  input  logic [IDX_W-1:0] voice_idx,
  output logic [IDX_W-1:0] oldest_idx
);

  logic [IDX_W-1:0] rank_q [N_VOICES];
  logic [IDX_W-1:0] old_rank;

  assign old_rank = rank_q[voice_idx];

  // Voices younger than the touched one age by one,
  // so the ranks stay a permutation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_VOICES; i++)
        rank_q[i] <= IDX_W'(i);
    end else if (touch) begin
      for (int i = 0; i < N_VOICES; i++) begin
        if (IDX_W'(i) == voice_idx)
          rank_q[i] <= '0;
        else if (rank_q[i] < old_rank)
          rank_q[i] <= rank_q[i] + IDX_W'(1);
      end
    end
  end

  always_comb begin
    oldest_idx = '0;
    for (int i = 0; i < N_VOICES; i++)
      if (rank_q[i] == IDX_W'(N_VOICES - 1))
        oldest_idx = IDX_W'(i);
  end

endmodule

// File: rtl/synth_voice_allocator.sv
// synth_voice_allocator: command handshake, synth config regs,
// note allocation with LRU stealing, enables and active count.
module synth_voice_allocator
  import synth_pkg::*;
#(
  parameter int N_VOICES    = 4,
  parameter int FCW_WIDTH   = DEF_FCW_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [FCW_WIDTH-1:0]          cmd_data,
  output logic [N_VOICES*FCW_WIDTH-1:0] carrier_fcws,
  output logic [N_VOICES-1:0]           note_en,
  output logic [FCW_WIDTH-1:0]          mod_fcw,
  output logic [SHIFT_WIDTH-1:0]        mod_shift,
  output logic [SHIFT_WIDTH-1:0]        synth_shift,
  output logic                          steal_pulse,
  output logic                          err_pulse,
  output logic [$clog2(N_VOICES+1)-1:0] active_count
);

  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int CNT_W = $clog2(N_VOICES + 1);

  state_e state_q, state_d;

  logic [2:0]           op_q;
  logic [FCW_WIDTH-1:0] data_q;

  logic [N_VOICES-1:0][FCW_WIDTH-1:0] fcw_q, fcw_d;
  logic [N_VOICES-1:0]                en_d;
  logic [FCW_WIDTH-1:0]               mod_fcw_d;
  logic [SHIFT_WIDTH-1:0]             mod_shift_d;
  logic [SHIFT_WIDTH-1:0]             synth_shift_d;
  logic                               steal_d;
  logic                               err_d;
  logic [CNT_W-1:0]                   cnt_d;

  logic [N_VOICES-1:0] match_vec;
  logic                match_any;
  logic [IDX_W-1:0]    match_idx;
  logic                free_any;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    oldest_idx;
  logic                touch;
  logic [IDX_W-1:0]    touch_idx;

  logic exec;
  logic is_mfcw, is_mshift, is_start;
  logic is_stop, is_sshift, is_off;

  assign exec      = (state_q == ST_EXEC);
  assign is_mfcw   = (op_q == OP_SET_MOD_FCW);
  assign is_mshift = (op_q == OP_SET_MOD_SHIFT);
  assign is_start  = (op_q == OP_NOTE_START);
  assign is_stop   = (op_q == OP_NOTE_STOP);
  assign is_sshift = (op_q == OP_SET_SYNTH_SHIFT);
  assign is_off    = (op_q == OP_ALL_OFF);

  assign carrier_fcws = fcw_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_IDLE;
    endcase
  end

  // Lowest index wins: scan downwards, last hit sticks.
  always_comb begin
    match_vec = '0;
    match_idx = '0;
    free_idx  = '0;
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      match_vec[i] = note_en[i] && (fcw_q[i] == data_q);
      if (match_vec[i])
        match_idx = IDX_W'(i);
      if (!note_en[i])
        free_idx = IDX_W'(i);
    end
    match_any = |match_vec;
    free_any  = ~&note_en;
  end

  voice_lru_rank #(
    .N_VOICES (N_VOICES),
    .IDX_W    (IDX_W)
  ) u_lru (
    .clk        (clk),
    .rst_n      (rst_n),
    .touch      (touch),
    .voice_idx  (touch_idx),
    .oldest_idx (oldest_idx)
  );

  always_comb begin
    fcw_d         = fcw_q;
    en_d          = note_en;
    mod_fcw_d     = mod_fcw;
    mod_shift_d   = mod_shift;
    synth_shift_d = synth_shift;
    steal_d       = 1'b0;
    err_d         = 1'b0;
    touch         = 1'b0;
    touch_idx     = '0;
    if (exec) begin
      unique case (1'b1)
        is_mfcw:   mod_fcw_d = data_q;
        is_mshift: mod_shift_d = data_q[SHIFT_WIDTH-1:0];
        is_sshift: synth_shift_d = data_q[SHIFT_WIDTH-1:0];
        is_off:    en_d = '0;
        is_stop: begin
          if (match_any)
            en_d[match_idx] = 1'b0;
        end
        is_start: begin
          if (data_q == '0) begin
            err_d = 1'b1;
          end else if (match_any) begin
            touch     = 1'b1;
            touch_idx = match_idx;
          end else if (free_any) begin
            fcw_d[free_idx] = data_q;
            en_d[free_idx]  = 1'b1;
            touch           = 1'b1;
            touch_idx       = free_idx;
          end else begin
            fcw_d[oldest_idx] = data_q;
            touch             = 1'b1;
            touch_idx         = oldest_idx;
            steal_d           = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N_VOICES; i++)
      cnt_d = cnt_d + CNT_W'(en_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      data_q       <= '0;
      fcw_q        <= '0;
      note_en      <= '0;
      mod_fcw      <= '0;
      mod_shift    <= '0;
      synth_shift  <= '0;
      steal_pulse  <= 1'b0;
      err_pulse    <= 1'b0;
      active_count <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_valid && cmd_ready) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
      fcw_q        <= fcw_d;
      note_en      <= en_d;
      mod_fcw      <= mod_fcw_d;
      mod_shift    <= mod_shift_d;
      synth_shift  <= synth_shift_d;
      steal_pulse  <= steal_d;
      err_pulse    <= err_d;
      active_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_synth_voice_allocator.sv
// tb_synth_voice_allocator: scoreboard bench for the voice
// allocator with an age-stamp reference model.
module tb_synth_voice_allocator;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int SW = 5;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [N*W-1:0] carrier_fcws;
  logic [N-1:0]  note_en;
  logic [W-1:0]  mod_fcw;
  logic [SW-1:0] mod_shift;
  logic [SW-1:0] synth_shift;
  logic          steal_pulse;
  logic          err_pulse;
  logic [CW-1:0] active_count;

  synth_voice_allocator #(
    .N_VOICES    (N),
    .FCW_WIDTH   (W),
    .SHIFT_WIDTH (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .carrier_fcws (carrier_fcws),
    .note_en      (note_en),
    .mod_fcw      (mod_fcw),
    .mod_shift    (mod_shift),
    .synth_shift  (synth_shift),
    .steal_pulse  (steal_pulse),
    .err_pulse    (err_pulse),
    .active_count (active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   mfcw;
    logic [SW-1:0]  mshift;
    logic [SW-1:0]  sshift;
    logic [N*W-1:0] fcws;
    logic [N-1:0]   en;
    logic [CW-1:0]  cnt;
    logic           steal;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0]  m_mfcw;
  logic [SW-1:0] m_mshift;
  logic [SW-1:0] m_sshift;
  logic [W-1:0]  m_fcw [N];
  logic [N-1:0]  m_en;
  int            m_stamp [N];
  int            m_time;

  task automatic model_reset();
    m_mfcw = '0;
    m_mshift = '0;
    m_sshift = '0;
    m_en = '0;
    m_time = 0;
    for (int i = 0; i < N; i++) begin
      m_fcw[i] = '0;
      m_stamp[i] = -i;
    end
  endtask

  task automatic model_exec(input logic [2:0] op,
                            input logic [W-1:0] d,
                            output exp_t e);
    int hit, free, old;
    e.steal = 1'b0;
    e.err = 1'b0;
    hit = -1;
    for (int i = 0; i < N; i++)
      if (hit < 0 && m_en[i] && m_fcw[i] == d) hit = i;
    case (op)
      3'd1: m_mfcw = d;
      3'd2: m_mshift = d[SW-1:0];
      3'd5: m_sshift = d[SW-1:0];
      3'd6: m_en = '0;
      3'd4: if (hit >= 0) m_en[hit] = 1'b0;
      3'd3: begin
        if (d == '0) begin
          e.err = 1'b1;
        end else if (hit >= 0) begin
          m_time++;
          m_stamp[hit] = m_time;
        end else begin
          free = -1;
          for (int i = 0; i < N; i++)
            if (free < 0 && !m_en[i]) free = i;
          m_time++;
          if (free >= 0) begin
            m_fcw[free] = d;
            m_en[free] = 1'b1;
            m_stamp[free] = m_time;
          end else begin
            old = 0;
            for (int i = 1; i < N; i++)
              if (m_stamp[i] < m_stamp[old]) old = i;
            m_fcw[old] = d;
            m_stamp[old] = m_time;
            e.steal = 1'b1;
          end
        end
      end
      default: e.err = 1'b1;
    endcase
    e.mfcw = m_mfcw;
    e.mshift = m_mshift;
    e.sshift = m_sshift;
    for (int i = 0; i < N; i++) e.fcws[i*W +: W] = m_fcw[i];
    e.en = m_en;
    e.cnt = CW'($countones(m_en));
  endtask

  // Scoreboard: a command completes when cmd_ready rises.
  logic prev_ready = 1'b1;
  logic prev_rst = 1'b0;
  exp_t me;

  always @(negedge clk) begin
    if (rst_n && prev_rst && cmd_ready === 1'b1 && prev_ready === 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected completion with empty queue");
      end else begin
        me = sb.pop_front();
        if ({mod_fcw, mod_shift, synth_shift} !==
            {me.mfcw, me.mshift, me.sshift}) begin
          errors++;
          $display("FAIL sb_cfg got %0h/%0h/%0h exp %0h/%0h/%0h",
                   mod_fcw, mod_shift, synth_shift,
                   me.mfcw, me.mshift, me.sshift);
        end
        checks++;
        if (carrier_fcws !== me.fcws) begin
          errors++;
          $display("FAIL sb_fcws got %0h exp %0h", carrier_fcws, me.fcws);
        end
        checks++;
        if ({note_en, active_count} !== {me.en, me.cnt}) begin
          errors++;
          $display("FAIL sb_en got %b/%0d exp %b/%0d",
                   note_en, active_count, me.en, me.cnt);
        end
        checks++;
        if ({steal_pulse, err_pulse} !== {me.steal, me.err}) begin
          errors++;
          $display("FAIL sb_pulse got %b%b exp %b%b",
                   steal_pulse, err_pulse, me.steal, me.err);
        end
      end
    end
    prev_ready = cmd_ready;
    prev_rst = rst_n;
  end

  // Returns on the falling edge inside the EXEC cycle.
  task automatic send(input logic [2:0] op, input logic [W-1:0] d,
                      input bit hold);
    exp_t e;
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout cmd_ready %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    model_exec(op, d, e);
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = hold;
    cmd_op = 3'($urandom);
    cmd_data = W'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b exp 1", cmd_ready);
    end
    checks++;
    if ({mod_fcw, mod_shift, synth_shift, carrier_fcws} !== '0) begin
      errors++;
      $display("FAIL rst_regs got %0h exp 0",
               {mod_fcw, mod_shift, synth_shift, carrier_fcws});
    end
    checks++;
    if ({note_en, active_count, steal_pulse, err_pulse} !== '0) begin
      errors++;
      $display("FAIL rst_en got %0h exp 0",
               {note_en, active_count, steal_pulse, err_pulse});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || note_en !== '0) begin
      errors++;
      $display("FAIL rst_release got %b/%b exp 1/0", cmd_ready, note_en);
    end
  endtask

  task automatic test_regs();
    logic [2:0] ops [3];
    logic [W-1:0] ds [3];
    logic [W-1:0] got;
    ops = '{3'd2, 3'd5, 3'd1};
    ds = '{W'(8), W'(2), W'(1118481)};
    for (int k = 0; k < 3; k++) begin
      send(ops[k], ds[k], 1'b0);
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL regs_ready_low k%0d got %b exp 0", k, cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL regs_ready_high k%0d got %b exp 1", k, cmd_ready);
      end
      got = (k == 0) ? W'(mod_shift) : (k == 1) ? W'(synth_shift) : mod_fcw;
      checks++;
      if (got !== ds[k]) begin
        errors++;
        $display("FAIL regs_val k%0d got %0d exp %0d", k, got, ds[k]);
      end
    end
  endtask

  task automatic test_alloc();
    send(3'd3, W'(2796202), 1'b0);
    @(negedge clk);
    send(3'd3, W'(1006202), 1'b0);
    @(negedge clk);
    checks++;
    if (note_en !== 4'b0011 || active_count !== 3'd2) begin
      errors++;
      $display("FAIL alloc_en got %b/%0d exp 0011/2", note_en, active_count);
    end
    checks++;
    if (carrier_fcws[0 +: W] !== W'(2796202) ||
        carrier_fcws[W +: W] !== W'(1006202)) begin
      errors++;
      $display("FAIL alloc_fcw got %0d/%0d exp 2796202/1006202",
               carrier_fcws[0 +: W], carrier_fcws[W +: W]);
    end
  endtask

  task automatic test_retrigger_stop();
    send(3'd3, W'(2796202), 1'b0);
    @(negedge clk);
    checks++;
    if (note_en !== 4'b0011 || steal_pulse !== 1'b0) begin
      errors++;
      $display("FAIL retrig got %b/%b exp 0011/0", note_en, steal_pulse);
    end
    send(3'd4, W'(2796202), 1'b0);
    @(negedge clk);
    checks++;
    if (note_en !== 4'b0010 || carrier_fcws[0 +: W] !== W'(2796202)) begin
      errors++;
      $display("FAIL stop got %b/%0d exp 0010/2796202",
               note_en, carrier_fcws[0 +: W]);
    end
  endtask

  task automatic test_steal();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      send(3'd3, W'(k * 100), 1'b0);
      @(negedge clk);
    end
    send(3'd3, W'(500), 1'b0);
    @(negedge clk);
    checks++;
    if (steal_pulse !== 1'b1 || carrier_fcws[0 +: W] !== W'(500) ||
        note_en !== 4'b1111) begin
      errors++;
      $display("FAIL steal0 got %b/%0d/%b exp 1/500/1111",
               steal_pulse, carrier_fcws[0 +: W], note_en);
    end
    @(negedge clk);
    checks++;
    if (steal_pulse !== 1'b0) begin
      errors++;
      $display("FAIL steal_width got %b exp 0", steal_pulse);
    end
    send(3'd3, W'(600), 1'b0);
    @(negedge clk);
    checks++;
    if (carrier_fcws[W +: W] !== W'(600) || steal_pulse !== 1'b1) begin
      errors++;
      $display("FAIL steal1 got %0d/%b exp 600/1",
               carrier_fcws[W +: W], steal_pulse);
    end
  endtask

  task automatic test_errors();
    send(3'd7, W'(1234), 1'b0);
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL err_op7 got %b exp 1", err_pulse);
    end
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL err_width got %b exp 0", err_pulse);
    end
    send(3'd3, W'(0), 1'b0);
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b1 || note_en !== 4'b1111) begin
      errors++;
      $display("FAIL err_fcw0 got %b/%b exp 1/1111", err_pulse, note_en);
    end
    send(3'd4, W'(999), 1'b0);
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0 || note_en !== 4'b1111) begin
      errors++;
      $display("FAIL stop_miss got %b/%b exp 0/1111", err_pulse, note_en);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    send(3'd3, W'(11), 1'b1);
    send(3'd3, W'(22), 1'b1);
    send(3'd3, W'(33), 1'b1);
    send(3'd2, W'(5), 1'b1);
    @(negedge clk);
    checks++;
    if (note_en !== 4'b0111 || mod_shift !== 5'd5) begin
      errors++;
      $display("FAIL b2b got %b/%0d exp 0111/5", note_en, mod_shift);
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_data = W'(777);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || mod_fcw !== '0 || note_en !== '0 ||
        active_count !== '0 || mod_shift !== '0) begin
      errors++;
      $display("FAIL rst_exec got %b/%0d/%b/%0d exp 1/0/0/0",
               cmd_ready, mod_fcw, note_en, active_count);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending got %0d exp 0", sb.size());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mod_fcw !== '0 || cmd_ready !== 1'b1 || carrier_fcws !== '0) begin
      errors++;
      $display("FAIL rst_drop got %0d/%b exp 0/1", mod_fcw, cmd_ready);
    end
  endtask

  task automatic test_all_off();
    send(3'd3, W'(10), 1'b0);
    send(3'd3, W'(20), 1'b0);
    send(3'd3, W'(30), 1'b0);
    @(negedge clk);
    checks++;
    if (active_count !== 3'd3) begin
      errors++;
      $display("FAIL off_pre got %0d exp 3", active_count);
    end
    send(3'd6, W'(0), 1'b0);
    @(negedge clk);
    checks++;
    if (note_en !== '0 || active_count !== '0 ||
        carrier_fcws[0 +: W] !== W'(10)) begin
      errors++;
      $display("FAIL all_off got %b/%0d/%0d exp 0/0/10",
               note_en, active_count, carrier_fcws[0 +: W]);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_alloc();
    test_retrigger_stop();
    test_steal();
    test_errors();
    test_back_to_back();
    test_all_off();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
